online_div_sequencer: RTL and testbench

ONLINE_DIV_SEQUENCER -- requirements
Module: online_div_sequencer

---
 rtl/online_div_sequencer.sv | 137 +++++++++++++
 tb/tb_online_div_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/online_div_sequencer.sv
// Online divider sequencer: steps a digit-serial divider through clear, operand
// feed, pipeline flush and completion, and re-times the quotient digit stream.
module online_div_sequencer #(
  parameter int PRECISION = 8,  // operand/quotient digit count, 1..256
  parameter int DELTA     = 4   // divider online delay in steps, 1..8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [1:0] x_digit,
  input  logic [1:0] y_digit,
  output logic       in_ready,
  output logic [1:0] div_x,
  output logic [1:0] div_y,
  output logic       div_en,
  output logic       div_clear,
  input  logic [1:0] div_z,
  output logic       z_valid,
  output logic [1:0] z_digit,
  output logic       z_last,
  output logic [8:0] digit_cnt,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Step index of the last operand pair and of the last flush step.
  localparam logic [9:0] LAST_FEED = 10'(PRECISION - 1);
  localparam logic [9:0] LAST_STEP = 10'(PRECISION + DELTA - 1);
  localparam logic [9:0] DELTA_K   = 10'(DELTA);

  state_e     state_q;
  logic [9:0] step_q;       // div_en cycles issued in this division
  logic [8:0] cnt_q;        // quotient digits emitted in this division
  logic       z_valid_q;
  logic       z_last_q;
  logic       abort_clr_q;  // clears the divider the cycle after an abort

  logic       running;
  logic       kill;
  logic       accept;
  logic       step_en;
  logic [1:0] x_fwd;
  logic [1:0] y_fwd;

  // Abort only cancels a division that is actually in flight, and it wins
  // over a digit pair offered in the same cycle.
  assign running = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_FLUSH);
  assign kill    = abort && running;
  assign accept  = (state_q == S_FEED) && in_valid && !abort;
  assign step_en = accept || ((state_q == S_FLUSH) && !abort);

  // Code 11 is not a legal borrow-save digit; it is forwarded as zero.
  assign x_fwd = (x_digit == 2'b11) ? 2'b00 : x_digit;
  assign y_fwd = (y_digit == 2'b11) ? 2'b00 : y_digit;

  // Divider controls are decoded from the registered state so an accepted
  // pair reaches the datapath in the same cycle it is handed over.
  assign in_ready  = (state_q == S_FEED);
  assign div_en    = step_en;
  assign div_x     = accept ? x_fwd : 2'b00;
  assign div_y     = accept ? y_fwd : 2'b00;
  assign div_clear = (state_q == S_CLEAR) || abort_clr_q;

  // div_z is already valid in the cycle the registered z_valid is raised;
  // gating keeps the digit at zero outside of valid beats.
  assign z_valid   = z_valid_q;
  assign z_last    = z_last_q;
  assign z_digit   = z_valid_q ? div_z : 2'b00;
  assign digit_cnt = cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state     = state_q;

  // Sequencer FSM with step/digit counters and registered digit-stream flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      z_valid_q   <= 1'b0;
      z_last_q    <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees
      // the pre-edge value and later assignments override the defaults.
      z_valid_q   <= 1'b0;
      z_last_q    <= 1'b0;
      abort_clr_q <= 1'b0;

      // Steps from DELTA onward each retire one quotient digit next cycle.
      if (step_en) begin
        step_q <= step_q + 10'd1;
        if (step_q >= DELTA_K) begin
          z_valid_q <= 1'b1;
          z_last_q  <= (step_q == LAST_STEP);
          cnt_q     <= cnt_q + 9'd1;
        end
      end

      if (kill) begin
        state_q     <= S_IDLE;
        abort_clr_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_CLEAR;
              step_q  <= '0;
              cnt_q   <= '0;
            end
          end
          S_CLEAR: state_q <= S_FEED;
          S_FEED: begin
            if (accept && (step_q == LAST_FEED)) state_q <= S_FLUSH;
          end
          S_FLUSH: begin
            if (step_q == LAST_STEP) state_q <= S_DONE;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_online_div_sequencer.sv
// Scoreboard bench for online_div_sequencer (PRECISION=8, DELTA=4). Stimulus
// tasks push expected divider steps, quotient beats and completions into
// queues; a monitor pops and compares whenever the DUT presents them.
module tb_online_div_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [1:0] x_digit;
  logic [1:0] y_digit;
  logic       in_ready;
  logic [1:0] div_x;
  logic [1:0] div_y;
  logic       div_en;
  logic       div_clear;
  logic [1:0] div_z;
  logic       z_valid;
  logic [1:0] z_digit;
  logic       z_last;
  logic [8:0] digit_cnt;
  logic       busy;
  logic       done;
  logic [2:0] state;

  online_div_sequencer #(.PRECISION(8), .DELTA(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .x_digit(x_digit), .y_digit(y_digit),
    .in_ready(in_ready), .div_x(div_x), .div_y(div_y), .div_en(div_en),
    .div_clear(div_clear), .div_z(div_z), .z_valid(z_valid),
    .z_digit(z_digit), .z_last(z_last), .digit_cnt(digit_cnt),
    .busy(busy), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] d;
    logic       last;
    logic [8:0] cnt;
  } z_exp_t;

  logic [3:0] exp_step_q[$];
  z_exp_t     exp_z_q[$];
  int         exp_done_q[$];

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;

  logic [1:0] px[8];
  logic [1:0] py[8];

  // Hand-computed quotient digits 0..7 produced by the divider stub below
  // (stub emits 10,01,00 repeating by step; digit i comes from step i+4).
  logic [1:0] exp_digits[8] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Divider stub: registers a step-indexed quotient digit on each div_en.
  int sk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk    <= 0;
      div_z <= 2'b00;
    end else if (div_clear) begin
      sk    <= 0;
      div_z <= 2'b00;
    end else if (div_en) begin
      case (sk % 3)
        0:       div_z <= 2'b10;
        1:       div_z <= 2'b01;
        default: div_z <= 2'b00;
      endcase
      sk <= sk + 1;
    end
  end

  // Monitor: compares every presented step, quotient beat and completion.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (div_en) begin
        if (exp_step_q.size() != 0) check("div_xy", {28'd0, div_x, div_y}, {28'd0, exp_step_q.pop_front()});
        else check("div_en_spurious", {31'd0, div_en}, 32'd0);
      end
      if (z_valid) begin
        if (exp_z_q.size() != 0) begin
          z_exp_t e;
          e = exp_z_q.pop_front();
          check("z_digit", {30'd0, z_digit}, {30'd0, e.d});
          check("z_last", {31'd0, z_last}, {31'd0, e.last});
          check("z_cnt", {23'd0, digit_cnt}, {23'd0, e.cnt});
        end else check("z_valid_spurious", {31'd0, z_valid}, 32'd0);
      end
      if (done) begin
        if (exp_done_q.size() != 0) begin
          check("done_cycle", cyc, exp_done_q.pop_front());
          check("done_cnt", {23'd0, digit_cnt}, 32'd8);
          check("done_busy", {31'd0, busy}, 32'd1);
        end else check("done_spurious", {31'd0, done}, 32'd0);
      end
    end
  end

  function automatic logic [1:0] fwd(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  // Pulse start from IDLE and verify the single CLEAR cycle; returns its cycle.
  task automatic start_div(output int c_clr);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c_clr = cyc;
    check("clear_state", {29'd0, state}, 32'd1);
    check("clear_pulse", {31'd0, div_clear}, 32'd1);
    check("clear_cnt", {23'd0, digit_cnt}, 32'd0);
  endtask

  // Offer lim pairs; after two acceptances optionally stall stall_len cycles.
  task automatic send_pairs(input int lim, input int stall_len, input bit feed_pulse);
    int i = 0;
    int st = 0;
    int guard = 0;
    while (i < lim && guard < 100) begin
      @(negedge clk);
      guard++;
      if (i == 2 && st < stall_len) begin
        in_valid = 1'b0; x_digit = 2'b00; y_digit = 2'b00; start = 1'b0;
        st++;
      end else begin
        in_valid = 1'b1; x_digit = px[i]; y_digit = py[i];
        start = feed_pulse && (i == 3);
      end
      #1;
      if (in_valid && in_ready) begin
        if (px[i] == 2'b11) begin
          check("code11_div_x", {30'd0, div_x}, 32'd0);
          check("code11_div_y", {30'd0, div_y}, {30'd0, py[i]});
        end
        i++;
      end
    end
    check("pairs_accepted", i, lim);
  endtask

  // Full division: optional stall, start pulse in FEED and start pulse in DONE.
  task automatic run_div(input int stall_len, input bit feed_pulse, input bit done_pulse);
    int c_clr;
    int guard = 0;
    for (int i = 0; i < 8; i++) exp_step_q.push_back({fwd(px[i]), fwd(py[i])});
    for (int i = 0; i < 4; i++) exp_step_q.push_back(4'b0000);
    for (int i = 0; i < 8; i++) exp_z_q.push_back('{d: exp_digits[i], last: (i == 7), cnt: 9'(i + 1)});
    start_div(c_clr);
    exp_done_q.push_back(c_clr + 13 + stall_len);
    send_pairs(8, stall_len, feed_pulse);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    while (state != 3'd4 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("reach_done", {29'd0, state}, 32'd4);
    if (done_pulse) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", {29'd0, state}, 32'd0);
    @(negedge clk);
    check("idle_holds", {29'd0, state}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("cnt_holds", {23'd0, digit_cnt}, 32'd8);
  endtask

  initial begin
    int c_clr;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    x_digit = 2'b00; y_digit = 2'b00;
    #12;
    check("reset_outputs", {7'd0, in_ready, div_en, div_clear, z_valid, z_last, done, busy,
                            digit_cnt, div_x, div_y, z_digit, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain division, start pulsed during DONE.
    px = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b01};
    py = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    run_div(0, 1'b0, 1'b1);

    // 3-cycle input stall after the second pair, start pulsed during FEED.
    px = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    py = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01};
    run_div(3, 1'b1, 1'b0);

    // Illegal code 11 on both operands.
    px = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10};
    py = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10};
    run_div(0, 1'b0, 1'b0);

    // Abort at step 5: one quotient digit, then clear and back to IDLE.
    for (int i = 0; i < 5; i++) exp_step_q.push_back({fwd(px[i]), fwd(py[i])});
    exp_z_q.push_back('{d: exp_digits[0], last: 1'b0, cnt: 9'd1});
    start_div(c_clr);
    send_pairs(5, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; x_digit = px[5]; y_digit = py[5]; abort = 1'b1;
    #1;
    check("abort_blocks_step", {31'd0, div_en}, 32'd0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_clear", {31'd0, div_clear}, 32'd1);
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("abort_clear_once", {31'd0, div_clear}, 32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of FEED.
    for (int i = 0; i < 3; i++) exp_step_q.push_back({fwd(px[i]), fwd(py[i])});
    start_div(c_clr);
    send_pairs(3, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {7'd0, in_ready, div_en, div_clear, z_valid, z_last, done, busy,
                                   digit_cnt, div_x, div_y, z_digit, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; x_digit = 2'b10; y_digit = 2'b10;
    repeat (4) @(negedge clk);
    check("post_reset_idle", {29'd0, state}, 32'd0);
    check("post_reset_no_step", {31'd0, div_en}, 32'd0);
    in_valid = 1'b0;

    // Normal division after the reset.
    px = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
    py = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10};
    run_div(0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("steps_drained", exp_step_q.size(), 0);
    check("digits_drained", exp_z_q.size(), 0);
    check("dones_drained", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
